// File: rtl/requant_pipe_pc_if.sv
// rtl/requant_pipe_pc_if.sv - input/output BRAM port bundle for the requantizer core
interface requant_pipe_pc_if #(
  parameter int BW_INDEX = 13,
  parameter int BW_DATA  = 32
);
  localparam int LANES = BW_DATA / 8;

  logic [BW_INDEX-1:0] ibuff_rindex;
  logic                ibuff_renable;
  logic [BW_DATA-1:0]  ibuff_rdata;
  logic [BW_INDEX-1:0] obuff_windex;
  logic                obuff_wenable;
  logic [LANES-1:0]    obuff_wbe;
  logic [BW_DATA-1:0]  obuff_wdata;

  modport master (
    output ibuff_rindex,
    output ibuff_renable,
    input  ibuff_rdata,
    output obuff_windex,
    output obuff_wenable,
    output obuff_wbe,
    output obuff_wdata
  );

  modport slave (
    input  ibuff_rindex,
    input  ibuff_renable,
    output ibuff_rdata,
    input  obuff_windex,
    input  obuff_wenable,
    input  obuff_wbe,
    input  obuff_wdata
  );
endinterface

// File: rtl/requant_pipe_pc.sv
// rtl/requant_pipe_pc.sv - per-channel int32 -> int8 streaming requantizer, four-stage pipeline
module requant_pipe_pc #(
  parameter int BW_INDEX    = 13,
  parameter int BW_DATA     = 32,
  parameter int MAX_CHANNEL = 64,
  localparam int LANES      = BW_DATA / 8,
  localparam int BW_CH      = $clog2(MAX_CHANNEL)
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                cfg_we,
  input  logic [BW_CH+1:0]    cfg_addr,
  input  logic [31:0]         cfg_wdata,
  input  logic                start,
  input  logic [BW_INDEX+1:0] num_elem,
  input  logic [BW_CH:0]      num_channel,
  input  logic signed [7:0]   out_zp,
  input  logic                relu_en,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  requant_pipe_pc_if.master   mem_bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [BW_INDEX+1:0] n_elem_r;
  logic [BW_INDEX+1:0] k_cnt;
  logic [BW_CH:0]      n_ch_r;
  logic [BW_CH:0]      ch_cnt;
  logic signed [7:0]   zp_r;
  logic                relu_r;
  logic                issue;
  logic                last_issue;
  logic                drain_ok;
  logic                run_start;

  logic signed [31:0]  bias_t [MAX_CHANNEL];
  logic signed [31:0]  m0_t   [MAX_CHANNEL];
  logic [4:0]          sh_t   [MAX_CHANNEL];
  logic [BW_CH-1:0]    cfg_ch;
  logic [1:0]          cfg_sel;
  logic                cfg_ok;

  logic                v1, last1;
  logic [BW_CH-1:0]    c1;
  logic                v2, last2;
  logic [BW_CH-1:0]    c2;
  logic signed [31:0]  acc2;
  logic                v3, last3;
  logic [4:0]          sh3;
  logic signed [63:0]  prod3;

  logic [LW-1:0]       lane_cnt;
  logic [BW_INDEX-1:0] word_cnt;
  logic [BW_DATA-1:0]  pack_buf;
  logic                out_wen;
  logic [BW_INDEX-1:0] out_widx;
  logic [LANES-1:0]    out_wbe;
  logic [BW_DATA-1:0]  out_wdata;

  logic signed [31:0]  bias1;
  logic signed [32:0]  sum1;
  logic signed [31:0]  acc1;
  logic signed [31:0]  m0_2;
  logic signed [63:0]  prod2;
  logic signed [64:0]  prod_ext;
  logic signed [64:0]  rnd;
  logic signed [64:0]  rq;
  logic signed [65:0]  zsum;
  logic signed [65:0]  lo;
  logic signed [7:0]   q;
  logic [BW_DATA-1:0]  pack_nx;
  logic [LANES-1:0]    be_nx;
  logic                flush;

  assign run_start  = (state == S_IDLE) && start;
  assign issue      = (state == S_RUN) && !hold;
  assign last_issue = issue && (k_cnt == n_elem_r - (BW_INDEX+2)'(1));
  // a pending final write is only retired on a non-hold cycle
  assign drain_ok   = !v1 && !v2 && !v3 && !(out_wen && hold);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (num_elem == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_issue) state_nx = S_DRAIN;
      S_DRAIN: if (drain_ok) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state    <= S_IDLE;
      n_elem_r <= '0;
      k_cnt    <= '0;
      n_ch_r   <= (BW_CH+1)'(1);
      ch_cnt   <= '0;
      zp_r     <= '0;
      relu_r   <= 1'b0;
    end else begin
      state <= state_nx;
      if (run_start) begin
        n_elem_r <= num_elem;
        n_ch_r   <= (num_channel == '0) ? (BW_CH+1)'(1) : num_channel;
        zp_r     <= out_zp;
        relu_r   <= relu_en;
        k_cnt    <= '0;
        ch_cnt   <= '0;
      end else if (issue) begin
        k_cnt  <= k_cnt + (BW_INDEX+2)'(1);
        ch_cnt <= (ch_cnt == n_ch_r - (BW_CH+1)'(1)) ? '0 : ch_cnt + (BW_CH+1)'(1);
      end else if (state == S_DONE) begin
        k_cnt <= '0;
      end
    end
  end

  assign cfg_ch  = cfg_addr[BW_CH+1:2];
  assign cfg_sel = cfg_addr[1:0];
  assign cfg_ok  = ({1'b0, cfg_ch} < (BW_CH+1)'(MAX_CHANNEL));

  // table is writable only while idle so a run always sees one coherent set
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int i = 0; i < MAX_CHANNEL; i++) begin
        bias_t[i] <= '0;
        m0_t[i]   <= '0;
        sh_t[i]   <= '0;
      end
    end else if (cfg_we && (state == S_IDLE) && cfg_ok) begin
      case (cfg_sel)
        2'd0:    bias_t[cfg_ch] <= cfg_wdata;
        2'd1:    m0_t[cfg_ch]   <= cfg_wdata;
        2'd2:    sh_t[cfg_ch]   <= cfg_wdata[4:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bias1 = bias_t[c1];
    sum1  = $signed({mem_bus.ibuff_rdata[31], mem_bus.ibuff_rdata[31:0]}) + $signed({bias1[31], bias1});
    acc1  = sum1[31:0];
    if (sum1[32] != sum1[31]) acc1 = sum1[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  end

  always_comb begin
    m0_2  = m0_t[c2];
    prod2 = $signed({{32{acc2[31]}}, acc2}) * $signed({{32{m0_2[31]}}, m0_2});
  end

  // round-half-up shift by 31+sh, then zero point and clamp
  always_comb begin
    prod_ext = $signed({prod3[63], prod3});
    rnd      = 65'sd1 <<< ({2'b00, sh3} + 7'd30);
    rq       = (prod_ext + rnd) >>> ({2'b00, sh3} + 7'd31);
    zsum     = $signed({rq[64], rq}) + $signed({{58{zp_r[7]}}, zp_r});
    lo       = relu_r ? $signed({{58{zp_r[7]}}, zp_r}) : -66'sd128;
    if (zsum > 66'sd127)  q = 8'sd127;
    else if (zsum < lo)   q = lo[7:0];
    else                  q = zsum[7:0];
  end

  always_comb begin
    pack_nx = pack_buf;
    pack_nx[lane_cnt*8 +: 8] = q;
    be_nx = '0;
    for (int i = 0; i < LANES; i++) be_nx[i] = (LW'(i) <= lane_cnt);
    flush = last3 || (lane_cnt == LW'(LANES-1));
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      c1        <= '0;
      v2        <= 1'b0;
      last2     <= 1'b0;
      c2        <= '0;
      acc2      <= '0;
      v3        <= 1'b0;
      last3     <= 1'b0;
      sh3       <= '0;
      prod3     <= '0;
      lane_cnt  <= '0;
      word_cnt  <= '0;
      pack_buf  <= '0;
      out_wen   <= 1'b0;
      out_widx  <= '0;
      out_wbe   <= '0;
      out_wdata <= '0;
    end else begin
      if (!hold) begin
        v1    <= issue;
        last1 <= last_issue;
        c1    <= ch_cnt[BW_CH-1:0];
        v2    <= v1;
        if (v1) begin
          acc2  <= acc1;
          c2    <= c1;
          last2 <= last1;
        end
        v3 <= v2;
        if (v2) begin
          prod3 <= prod2;
          sh3   <= sh_t[c2];
          last3 <= last2;
        end
        out_wen <= 1'b0;
        if (v3) begin
          if (flush) begin
            out_wen   <= 1'b1;
            out_widx  <= word_cnt;
            out_wbe   <= be_nx;
            out_wdata <= pack_nx;
            word_cnt  <= word_cnt + BW_INDEX'(1);
            lane_cnt  <= '0;
            pack_buf  <= '0;
          end else begin
            lane_cnt <= lane_cnt + LW'(1);
            pack_buf <= pack_nx;
          end
        end
      end
      if (run_start) begin
        lane_cnt <= '0;
        word_cnt <= '0;
        pack_buf <= '0;
      end
    end
  end

  assign busy                  = (state != S_IDLE);
  assign done                  = (state == S_DONE);
  assign mem_bus.ibuff_renable = issue;
  assign mem_bus.ibuff_rindex  = k_cnt[BW_INDEX-1:0];
  assign mem_bus.obuff_windex  = out_widx;
  assign mem_bus.obuff_wenable = out_wen && !hold;
  assign mem_bus.obuff_wbe     = out_wbe;
  assign mem_bus.obuff_wdata   = out_wdata;

endmodule

// File: tb/tb_requant_pipe_pc.sv
// tb/tb_requant_pipe_pc.sv - vector table plus write scoreboard for requant_pipe_pc
module tb_requant_pipe_pc;
  localparam int BW_INDEX = 13;
  localparam int BW_DATA  = 32;
  localparam int MAX_CH   = 64;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        start = 1'b0;
  logic [14:0] num_elem = '0;
  logic [6:0]  num_channel = '0;
  logic [7:0]  out_zp = '0;
  logic        relu_en = 1'b0;
  logic        hold = 1'b0;
  logic        busy, done;

  always #5 clk = ~clk;

  requant_pipe_pc_if #(.BW_INDEX(BW_INDEX), .BW_DATA(BW_DATA)) mem_if ();

  requant_pipe_pc #(.BW_INDEX(BW_INDEX), .BW_DATA(BW_DATA), .MAX_CHANNEL(MAX_CH)) dut (
    .clk(clk), .rstnn(rstnn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .num_elem(num_elem), .num_channel(num_channel), .out_zp(out_zp),
    .relu_en(relu_en), .hold(hold), .busy(busy), .done(done), .mem_bus(mem_if)
  );

  logic [31:0] mem [0:31];
  always @(posedge clk)
    if (mem_if.ibuff_renable) mem_if.ibuff_rdata <= mem[mem_if.ibuff_rindex[4:0]];

  typedef struct { int idx; logic [3:0] wbe; logic [31:0] data; } wr_t;
  typedef struct {
    int n; int nch; int zp; bit relu;
    int bias[3]; int m0[3]; int sh[3]; int din[8]; int dout[8];
  } vec_t;

  wr_t        exp_q[$];
  vec_t       vt[5];
  logic [7:0] exp_b [0:31];
  int total = 0, bad = 0, done_cnt = 0, wr_cnt = 0;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] q_model(int x, int b, int m, int s, int zp, bit relu);
    longint acc, p, lo;
    acc = longint'(x) + longint'(b);
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    p = acc * longint'(m);
    p = (p + (longint'(1) <<< (30 + s))) >>> (31 + s);
    p = p + longint'(zp);
    lo = relu ? longint'(zp) : -128;
    if (p > 127) p = 127;
    if (p < lo) p = lo;
    return p[7:0];
  endfunction

  always @(negedge clk) begin
    wr_t e;
    logic [31:0] m;
    if (rstnn && done) done_cnt++;
    if (rstnn && mem_if.obuff_wenable) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        for (int l = 0; l < 4; l++) m[l*8 +: 8] = {8{e.wbe[l]}};
        chk("windex", longint'(mem_if.obuff_windex), longint'(e.idx));
        chk("wbe", longint'(mem_if.obuff_wbe), longint'(e.wbe));
        chk("wdata", longint'(mem_if.obuff_wdata & m), longint'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(int ch, int sel, int d);
    cfg_addr = {6'(ch), 2'(sel)};
    cfg_wdata = 32'(d);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic push_expected(int n);
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      e.idx = w; e.wbe = '0; e.data = '0;
      for (int l = 0; l < 4; l++)
        if (w * 4 + l < n) begin
          e.wbe[l] = 1'b1;
          e.data[l*8 +: 8] = exp_b[w*4 + l];
        end
      exp_q.push_back(e);
    end
  endtask

  task automatic run(int n, int nch, int zp, bit relu, bit tog, bit disturb);
    int d0, cyc;
    push_expected(n);
    num_elem = 15'(n); num_channel = 7'(nch); out_zp = 8'(zp); relu_en = relu;
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt; cyc = 0;
    while (done_cnt == d0 && cyc < 400) begin
      if (tog) hold = ~hold;
      if (disturb && cyc == 3) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = {6'd1, 2'd0}; cfg_wdata = 32'd77;
      end else if (disturb && cyc == 4) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      tick();
      cyc++;
    end
    hold = 1'b0; start = 1'b0; cfg_we = 1'b0;
    chk("done_seen", longint'(done_cnt > d0), 1);
    repeat (3) tick();
    chk("done_once", done_cnt - d0, 1);
    chk("busy_after", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, d0, cyc, nprog;
    int hb[3], hm[3], hs[3];

    vt[0] = '{n:4, nch:1, zp:0, relu:0, bias:'{0,0,0}, m0:'{32'h4000_0000,0,0}, sh:'{0,0,0},
              din:'{100,101,-101,1000,0,0,0,0}, dout:'{50,51,-50,127,0,0,0,0}};
    vt[1] = '{n:4, nch:0, zp:-5, relu:1, bias:'{0,0,0}, m0:'{32'h4000_0000,0,0}, sh:'{0,0,0},
              din:'{-100,10,0,20,0,0,0,0}, dout:'{-5,0,-5,5,0,0,0,0}};
    vt[2] = '{n:7, nch:3, zp:0, relu:0, bias:'{0,10,20},
              m0:'{32'h7FFF_FFFF,32'h7FFF_FFFF,32'h7FFF_FFFF}, sh:'{0,0,0},
              din:'{0,0,0,0,0,0,0,0}, dout:'{0,10,20,0,10,20,0,0}};
    vt[3] = '{n:3, nch:2, zp:0, relu:0, bias:'{1,-1,0}, m0:'{32'h7FFF_FFFF,32'h7FFF_FFFF,0},
              sh:'{28,28,0}, din:'{32'h7FFF_FFFF,int'(32'h8000_0000),100,0,0,0,0,0},
              dout:'{8,-8,0,0,0,0,0,0}};
    vt[4] = '{n:5, nch:1, zp:100, relu:0, bias:'{0,0,0}, m0:'{32'h4000_0000,0,0}, sh:'{1,0,0},
              din:'{200,-1000,4,-6,10,0,0,0}, dout:'{127,-128,101,99,103,0,0,0}};

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_renable", mem_if.ibuff_renable, 0);
    chk("rst_rindex", mem_if.ibuff_rindex, 0);
    chk("rst_wenable", mem_if.obuff_wenable, 0);
    chk("rst_wdata", mem_if.obuff_wdata, 0);
    rstnn = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      nprog = (vt[v].nch == 0) ? 1 : vt[v].nch;
      for (int ch = 0; ch < nprog; ch++) begin
        cfg_write(ch, 0, vt[v].bias[ch]);
        cfg_write(ch, 1, vt[v].m0[ch]);
        cfg_write(ch, 2, vt[v].sh[ch]);
      end
      for (int i = 0; i < vt[v].n; i++) begin
        mem[i] = 32'(vt[v].din[i]);
        exp_b[i] = 8'(vt[v].dout[i]);
      end
      run(vt[v].n, vt[v].nch, vt[v].zp, vt[v].relu, 1'b0, v == 2);
      if (v == 2) run(vt[v].n, vt[v].nch, vt[v].zp, vt[v].relu, 1'b0, 1'b0);
    end

    // 16 elements over three channels, hold-free then with hold toggling
    hb = '{5, -7, 1000};
    hm = '{32'h4000_0000, 32'h7FFF_FFFF, 32'h1234_5678};
    hs = '{0, 3, 10};
    for (int ch = 0; ch < 3; ch++) begin
      cfg_write(ch, 0, hb[ch]);
      cfg_write(ch, 1, hm[ch]);
      cfg_write(ch, 2, hs[ch]);
    end
    for (int i = 0; i < 16; i++) begin
      mem[i] = (i % 5 == 0) ? $urandom : 32'(int'($urandom_range(0, 4000)) - 2000);
      exp_b[i] = q_model(int'(mem[i]), hb[i % 3], hm[i % 3], hs[i % 3], 2, 1'b0);
    end
    run(16, 3, 2, 1'b0, 1'b0, 1'b0);
    run(16, 3, 2, 1'b0, 1'b1, 1'b0);

    // zero-length run
    w0 = wr_cnt; d0 = done_cnt; cyc = 0;
    num_elem = '0; start = 1'b1;
    tick();
    start = 1'b0;
    while (done_cnt == d0 && cyc < 3) begin tick(); cyc++; end
    repeat (3) tick();
    chk("zero_done_once", done_cnt - d0, 1);
    chk("zero_no_writes", wr_cnt - w0, 0);

    // reset at element 5 of 16
    w0 = wr_cnt; cyc = 0;
    num_elem = 15'd16; num_channel = 7'd3; start = 1'b1;
    tick();
    start = 1'b0;
    while (!(mem_if.ibuff_renable && mem_if.ibuff_rindex == 13'd5) && cyc < 50) begin tick(); cyc++; end
    chk("reached_elem5", mem_if.ibuff_rindex, 5);
    #2 rstnn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_renable", mem_if.ibuff_renable, 0);
    chk("abort_rindex", mem_if.ibuff_rindex, 0);
    chk("abort_wenable", mem_if.obuff_wenable, 0);
    chk("abort_wbe", mem_if.obuff_wbe, 0);
    chk("abort_windex", mem_if.obuff_windex, 0);
    chk("abort_wdata", mem_if.obuff_wdata, 0);
    repeat (2) tick();
    rstnn = 1'b1;
    repeat (20) tick();
    chk("abort_no_writes", wr_cnt - w0, 0);
    chk("abort_idle", busy, 0);

    // cleared table: M0=0 leaves only the zero point
    for (int i = 0; i < 6; i++) begin
      mem[i] = 32'(i * 1000 - 2500);
      exp_b[i] = 8'd3;
    end
    run(6, 1, 3, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
